// File: rtl/alu_arb_pkg.sv
// Shared state encoding, opcode constants and index helper for the ALU request arbiter.
package alu_arb_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  function automatic int wrap_idx(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Combinational grant selection: round-robin from last_grant+1, or fixed priority
// (lowest index wins) when ALU_ARB_PRIO_EN is defined.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant
);

`ifdef ALU_ARB_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`else
  int   idx;
  logic found;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = wrap_idx(int'(last_grant), i, N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between N_REQ requesters: accept, issue, wait ALU_LAT cycles, respond.
// Define ALU_ARB_PRIO_EN for fixed-priority grant instead of round-robin.
//
// state | meaning
// IDLE  | look for a valid request, grant one, latch its operands
// ISSUE | drive latched operands to the ALU with enable high (1 cycle)
// WAIT  | hold operands/enable for ALU_LAT cycles, capture result on the last one
// RESP  | present result to the granted requester until it accepts
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int N_ALU   = 4,
  parameter int N_REQ   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*WIDTH*N_ALU-1:0] req_a,
  input  logic [N_REQ*WIDTH*N_ALU-1:0] req_b,
  input  logic [N_REQ*SEL_W-1:0]       req_sel,
  output logic [N_REQ-1:0]             rsp_valid,
  input  logic [N_REQ-1:0]             rsp_ready,
  output logic [WIDTH*N_ALU*8-1:0]     rsp_data,
  output logic                         rsp_carry,
  output logic [WIDTH*N_ALU-1:0]       alu_a,
  output logic [WIDTH*N_ALU-1:0]       alu_b,
  output logic [SEL_W-1:0]             alu_select,
  output logic                         alu_enable,
  input  logic [WIDTH*N_ALU*8-1:0]     alu_out,
  input  logic                         alu_carry_out
);

  localparam int D     = WIDTH * N_ALU;
  localparam int RW    = D * 8;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_RESP  = ST_RESP;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [D-1:0]     alu_a_q, alu_a_d;
  logic [D-1:0]     alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic [RW-1:0]    rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             accept;

  alu_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  assign accept = (state_q == S_IDLE) && (|req_valid);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          gnt_d        = grant;
          last_grant_d = grant_idx;
          alu_a_d      = req_a[int'(grant_idx)*D +: D];
          alu_b_d      = req_b[int'(grant_idx)*D +: D];
          alu_sel_d    = req_sel[int'(grant_idx)*SEL_W +: SEL_W];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(ALU_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = alu_out;
          rsp_carry_d = alu_carry_out;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        // Only the granted requester's ready bit completes the handshake.
        if (|(rsp_ready & gnt_q)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= OP_ADD;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  // Gated by arst so a grant is never shown in a cycle whose accept reset discards.
  assign req_ready  = (accept && !arst) ? grant : '0;
  assign rsp_valid  = (state_q == S_RESP) ? gnt_q : '0;
  assign alu_enable = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_sel_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_carry  = rsp_carry_q;

endmodule
